audio_bus_arbiter: RTL and testbench

//  Shares the audio output bus between NUM_REQ audio packet processors. Each processor raises req

---
 rtl/audio_bus_arbiter.sv | 149 ++++++++++++++
 tb/tb_audio_bus_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_bus_arbiter.sv
// Round-robin arbiter for the shared audio output bus: HOLD window, per-grant bus key, turnaround GAP.
// Optional AUDIO_ARB_PRIO0_EN gives requester 0 absolute priority in every arbitration.
module audio_bus_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 16,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         req_done,
  input  logic [8*NUM_REQ-1:0]       req_dev_id,
  input  logic [DATA_W*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       bus_busy,
  output logic                       bus_valid,
  output logic [7:0]                 bus_dev_id,
  output logic [DATA_W-1:0]          bus_data,
  output logic [7:0]                 bus_key,
  output logic [1:0]                 state_dbg
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 2);

  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, GAP = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     rr_ptr, owner, win, scan_idx;
  logic [7:0]        grant_cnt;
  logic [HW-1:0]     hold_cnt;
  logic [GW-1:0]     gap_cnt;
  logic [7:0]        win_dev;
  logic [DATA_W-1:0] win_data;
  logic              any_req, do_grant, do_release, to_idle;

  assign any_req   = |req;
  assign state_dbg = state;

  // Scan from the far end back to rr_ptr so the nearest asserted request wins.
  always_comb begin
    win      = '0;
    scan_idx = '0;
    win_dev  = '0;
    win_data = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = PW'((int'(rr_ptr) + k) % NUM_REQ);
      if (req[scan_idx]) win = scan_idx;
    end
`ifdef AUDIO_ARB_PRIO0_EN
    if (req[0]) win = '0;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == PW'(i)) begin
        win_dev  = req_dev_id[8*i +: 8];
        win_data = req_data[DATA_W*i +: DATA_W];
      end
    end
  end

  // The last GAP edge doubles as the first IDLE arbitration edge, so a held
  // request is re-granted without a dead cycle.
  always_comb begin
    state_nxt  = state;
    do_grant   = 1'b0;
    do_release = 1'b0;
    to_idle    = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          do_grant  = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (hold_cnt == '0 || req_done[owner] || !req[owner]) begin
          do_release = 1'b1;
          if (GAP_CYCLES == 0) begin
            to_idle   = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = GAP;
          end
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          if (any_req) begin
            do_grant  = 1'b1;
            state_nxt = HOLD;
          end else begin
            to_idle   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      grant_cnt  <= '0;
      hold_cnt   <= '0;
      gap_cnt    <= '0;
      grant      <= '0;
      bus_busy   <= 1'b0;
      bus_valid  <= 1'b0;
      bus_dev_id <= '0;
      bus_data   <= '0;
      bus_key    <= '0;
    end else begin
      state <= state_nxt;
      if (do_grant) begin
        owner      <= win;
        grant      <= NUM_REQ'(1) << win;
        bus_busy   <= 1'b1;
        bus_valid  <= 1'b1;
        bus_dev_id <= win_dev;
        bus_data   <= win_data;
        bus_key    <= win_dev ^ grant_cnt;
        grant_cnt  <= grant_cnt + 8'd1;
        hold_cnt   <= HW'(HOLD_CYCLES - 1);
`ifdef AUDIO_ARB_PRIO0_EN
        if (win != '0) rr_ptr <= PW'((int'(win) + 1) % NUM_REQ);
`else
        rr_ptr <= PW'((int'(win) + 1) % NUM_REQ);
`endif
      end else if (state == HOLD) begin
        if (do_release) begin
          grant     <= '0;
          bus_valid <= 1'b0;
          gap_cnt   <= GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
        end else begin
          hold_cnt <= hold_cnt - HW'(1);
        end
      end else if (state == GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GW'(1);
      end
      if (to_idle) bus_busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_audio_bus_arbiter.sv
// Scoreboard bench for audio_bus_arbiter: a transaction-level model predicts each grant
// (winner, latched fields, key, hold length); a monitor pops and compares on every grant.
module tb_audio_bus_arbiter;
  localparam int N = 4, DW = 16, HOLD = 16, GAP = 2;

  logic            clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0]    req = '0, req_done = '0;
  logic [8*N-1:0]  req_dev_id = '0;
  logic [DW*N-1:0] req_data = '0;
  logic [N-1:0]    grant;
  logic            bus_busy, bus_valid;
  logic [7:0]      bus_dev_id, bus_key;
  logic [DW-1:0]   bus_data;
  logic [1:0]      state_dbg;

  audio_bus_arbiter #(.NUM_REQ(N), .DATA_W(DW), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_done(req_done), .req_dev_id(req_dev_id),
    .req_data(req_data), .grant(grant), .bus_busy(bus_busy), .bus_valid(bus_valid),
    .bus_dev_id(bus_dev_id), .bus_data(bus_data), .bus_key(bus_key), .state_dbg(state_dbg));

  always #5 clk = ~clk;

  typedef struct {
    int              idx;
    logic [7:0]      dev;
    logic [DW-1:0]   data;
    logic [7:0]      key;
    int              len;
  } exp_t;

  exp_t       exp_q[$];
  logic [N-1:0] obs_grant[$];
  logic [7:0] obs_key[$];
  int         checks = 0, errors = 0;
  bit         mon_en = 1'b0;
  int         m_rr = 0;
  logic [7:0] m_cnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, want);
    end
  endtask

  // Reference model: one call per grant the arbiter is expected to issue.
  task automatic predict(input logic [N-1:0] mask, input int len, output int w);
    exp_t e;
    w = -1;
`ifdef AUDIO_ARB_PRIO0_EN
    if (mask[0]) w = 0;
`endif
    for (int k = 0; k < N && w < 0; k++)
      if (((mask >> ((m_rr + k) % N)) & 1) != 0) w = (m_rr + k) % N;
    e.idx  = w;
    e.dev  = 8'(req_dev_id >> (8 * w));
    e.data = DW'(req_data >> (DW * w));
    e.key  = e.dev ^ m_cnt;
    e.len  = len;
    m_cnt  = m_cnt + 8'd1;
`ifdef AUDIO_ARB_PRIO0_EN
    if (w != 0) m_rr = (w + 1) % N;
`else
    m_rr = (w + 1) % N;
`endif
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_rr = 0;
    m_cnt = '0;
    exp_q.delete();
  endtask

  task automatic scramble();
    for (int i = 0; i < N; i++) begin
      req_dev_id[8*i +: 8] = 8'($urandom);
      req_data[DW*i +: DW] = DW'($urandom);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_busy"}, bus_busy, 0);
    chk({tag, "_valid"}, bus_valid, 0);
    chk({tag, "_key"}, bus_key, 0);
    chk({tag, "_dev"}, bus_dev_id, 0);
    chk({tag, "_data"}, bus_data, 0);
  endtask

  task automatic wait_grant(input bit want, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if ((grant != 0) == want) ok = 1'b1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_grant actual=%b required_level=%0d", grant, want);
    end
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (!bus_busy) ok = 1'b1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_idle actual_busy=%0d required=0", bus_busy);
    end
  endtask

  // mode: 0 full hold, 1 req_done pulse at hold cycle k, 2 drop req at cycle k (last grant only), 3 random
  task automatic pick_rel(input int mode_in, input int k_in, input bit last, output int mode, output int k);
    mode = mode_in;
    k = k_in;
    if (mode_in == 3) begin
      mode = $urandom_range(0, last ? 2 : 1);
      k = $urandom_range(1, HOLD);
    end else if (mode_in == 2 && !last) begin
      mode = 1;
    end
  endtask

  task automatic run_burst(input logic [N-1:0] mask, input int n, input int mode_in,
                           input int k_in, input bit scr);
    int w, nw, mode, k, nmode, nk;
    bit ok;
    nw = 0; nmode = 0; nk = 0;
    req = mask;
    pick_rel(mode_in, k_in, n == 1, mode, k);
    predict(mask, (mode == 0) ? HOLD : k, w);
    for (int j = 0; j < n; j++) begin
      wait_grant(1'b1, ok);
      if (!ok) begin
        req = '0;
        return;
      end
      if (scr) scramble();
      if (j < n - 1) begin
        pick_rel(mode_in, k_in, j + 1 == n - 1, nmode, nk);
        predict(mask, (nmode == 0) ? HOLD : nk, nw);
      end
      if (mode != 0) begin
        for (int c = 1; c < k; c++) @(negedge clk);
        if (mode == 1) req_done = N'(1) << w;
        else req = req & ~(N'(1) << w);
        @(negedge clk);
        req_done = '0;
      end
      wait_grant(1'b0, ok);
      if (j == n - 1 || !ok) req = '0;
      w = nw; mode = nmode; k = nk;
    end
  endtask

  task automatic hard_reset();
    @(negedge clk);
    #1 mon_en = 1'b0;
    rst_n = 1'b0;
    #1 check_zero("reset");
    model_reset();
    @(negedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  // Monitor: pops one expectation per grant and tracks hold length and gap length.
  initial begin
    logic [N-1:0] prev;
    int len, gap;
    bit after_fall;
    exp_t cur;
    prev = '0; len = 0; gap = 0; after_fall = 1'b0;
    cur = '{idx: 0, dev: 8'h0, data: '0, key: 8'h0, len: 0};
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev = '0; len = 0; gap = 0; after_fall = 1'b0;
        continue;
      end
      chk("valid_eq_grant", bus_valid, grant != 0);
      chk("grant_onehot0", $onehot0(grant), 1);
      if (grant != 0) chk("busy_in_hold", bus_busy, 1);
      if (grant != 0 && prev == 0) begin
        if (after_fall) chk("gap_len", gap, GAP);
        after_fall = 1'b0;
        gap = 0;
        len = 1;
        obs_grant.push_back(grant);
        obs_key.push_back(bus_key);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_grant actual=%b required=none", grant);
        end else begin
          cur = exp_q.pop_front();
          chk("grant_sel", grant, 32'(1) << cur.idx);
          chk("dev_id", bus_dev_id, cur.dev);
          chk("data", bus_data, cur.data);
          chk("key", bus_key, cur.key);
        end
      end else if (grant != 0) begin
        len++;
        chk("key_stable", bus_key, cur.key);
      end else if (prev != 0) begin
        chk("hold_len", len, cur.len);
        chk("key_held", bus_key, cur.key);
        chk("busy_in_gap", bus_busy, 1);
        after_fall = 1'b1;
        gap = 1;
      end else if (after_fall) begin
        if (bus_busy) gap++;
        else begin
          chk("gap_len", gap, GAP);
          after_fall = 1'b0;
        end
      end
      prev = grant;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]   k3[5];
    logic [N-1:0] g3[5];
    int           w;
`ifdef AUDIO_ARB_PRIO0_EN
    k3 = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    g3 = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    k3 = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h14};
    g3 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    repeat (3) @(negedge clk);
    check_zero("por");
    #1 rst_n = 1'b1;
    mon_en = 1'b1;

    // Round-robin with all requesters held.
    req_dev_id = {8'h13, 8'h12, 8'h11, 8'h10};
    req_data = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
    obs_key.delete(); obs_grant.delete();
    run_burst(4'b1111, 5, 0, 0, 1'b0);
    wait_idle();
    chk("rr_count", obs_key.size(), 5);
    for (int i = 0; i < 5 && i < obs_key.size(); i++) begin
      chk($sformatf("rr_grant%0d", i), obs_grant[i], g3[i]);
      chk($sformatf("rr_key%0d", i), obs_key[i], k3[i]);
    end

    // Single request after reset.
    hard_reset();
    req_dev_id = {8'h00, 8'h00, 8'hA5, 8'h00};
    req_data = {16'h0, 16'h0, 16'h00AB, 16'h0};
    run_burst(4'b0010, 1, 0, 0, 1'b0);
    wait_idle();
    chk("single_grant", obs_grant[$], 4'b0010);
    chk("single_key", obs_key[$], 8'hA5);

    // Early release by req_done on hold cycle 3, then by dropping req.
    scramble();
    run_burst(4'b1100, 2, 1, 3, 1'b1);
    wait_idle();
    run_burst(4'b0110, 2, 2, 3, 1'b1);
    wait_idle();

    // Async reset in the middle of a hold window.
    scramble();
    predict(4'b1110, HOLD, w);
    req = 4'b1110;
    begin
      bit ok;
      wait_grant(1'b1, ok);
    end
    repeat (4) @(negedge clk);
    #1 mon_en = 1'b0;
    rst_n = 1'b0;
    #1 check_zero("midhold");
    model_reset();
    req = 4'b1111;
    @(negedge clk);
    check_zero("midhold_edge");
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
    run_burst(4'b1111, 1, 0, 0, 1'b0);
    wait_idle();
    chk("post_reset_grant", obs_grant[$], 4'b0001);
    chk("post_reset_key", obs_key[$], req_dev_id[7:0]);

    // Randomized bursts.
    for (int b = 0; b < 40; b++) begin
      scramble();
      run_burst(N'($urandom_range(1, 15)), $urandom_range(1, 4), 3, 0, 1'b1);
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
